// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-clock divider, H/V counters and registered sync/blank/coordinate decode.
// Optional prefetch coordinates are compiled in when VGA_TIMING_PREFETCH_EN is defined.
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CLK_DIV    = 4,
  parameter int CW         = 10,
  parameter int FETCH_LEAD = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  output logic          pix_ce,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          de,
  output logic [CW-1:0] current_x,
  output logic [CW-1:0] current_y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_valid
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  // One extra bit so a sync end or total equal to 2**CW stays representable.
  localparam logic [CW:0] H_ACT_W  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG_W = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END_W = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_W  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG_W = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END_W = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**CW");
  end
  if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1) begin : g_bad_len
    $error("vga_timing_gen: active and sync lengths must be non-zero");
  end
  if (H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_porch
    $error("vga_timing_gen: porch lengths must be non-negative");
  end
  if (FETCH_LEAD < 1 || FETCH_LEAD > H_TOTAL - 1) begin : g_bad_lead
    $error("vga_timing_gen: FETCH_LEAD must be in 1..H_TOTAL-1");
  end

  logic [DW-1:0] div_reg;
  logic [CW-1:0] h_cnt_reg, v_cnt_reg;
  logic [CW-1:0] h_next, v_next;
  logic          tick;

  logic          pix_ce_reg, hs_reg, vs_reg, blank_reg, ls_reg, fs_reg;
  logic [CW-1:0] x_reg, y_reg;

  logic          h_act, v_act, hs_d, vs_d;

  assign tick = en && (div_reg == DIV_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_reg <= '0;
    end else if (en) begin
      div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    end
  end

  always_comb begin
    h_next = h_cnt_reg;
    v_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_next = h_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (tick) begin
      h_cnt_reg <= h_next;
      v_cnt_reg <= v_next;
    end
  end

  always_comb begin
    h_act = {1'b0, h_cnt_reg} < H_ACT_W;
    v_act = {1'b0, v_cnt_reg} < V_ACT_W;
    hs_d  = (({1'b0, h_cnt_reg} >= HS_BEG_W) && ({1'b0, h_cnt_reg} < HS_END_W)) ? HS_POL : ~HS_POL;
    vs_d  = (({1'b0, v_cnt_reg} >= VS_BEG_W) && ({1'b0, v_cnt_reg} < VS_END_W)) ? VS_POL : ~VS_POL;
  end

  // Outputs show the position the counters hold before advancing: one pixel of latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_ce_reg <= 1'b0;
      hs_reg     <= ~HS_POL;
      vs_reg     <= ~VS_POL;
      blank_reg  <= 1'b1;
      x_reg      <= '0;
      y_reg      <= '0;
      ls_reg     <= 1'b0;
      fs_reg     <= 1'b0;
    end else begin
      pix_ce_reg <= tick;
      ls_reg     <= tick && (h_cnt_reg == '0);
      fs_reg     <= tick && (h_cnt_reg == '0) && (v_cnt_reg == '0);
      if (tick) begin
        hs_reg    <= hs_d;
        vs_reg    <= vs_d;
        blank_reg <= ~(h_act && v_act);
        x_reg     <= (h_act && v_act) ? h_cnt_reg : '0;
        y_reg     <= (h_act && v_act) ? v_cnt_reg : '0;
      end
    end
  end

  // Pulses are masked by en so nothing strobes during a hold.
  assign pix_ce      = pix_ce_reg & en;
  assign line_start  = ls_reg & en;
  assign frame_start = fs_reg & en;
  assign hs          = hs_reg;
  assign vs          = vs_reg;
  assign blank       = blank_reg;
  assign de          = ~blank_reg;
  assign current_x   = x_reg;
  assign current_y   = y_reg;

`ifdef VGA_TIMING_PREFETCH_EN
  logic [CW:0]   fh_sum, fh;
  logic [CW-1:0] fv;
  logic          f_wrap, f_act;
  logic [CW-1:0] fx_reg, fy_reg;
  logic          fvalid_reg;

  always_comb begin
    fh_sum = {1'b0, h_cnt_reg} + (CW+1)'(FETCH_LEAD);
    f_wrap = fh_sum >= (CW+1)'(H_TOTAL);
    fh     = f_wrap ? fh_sum - (CW+1)'(H_TOTAL) : fh_sum;
    fv     = v_cnt_reg;
    if (f_wrap) begin
      fv = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end
    f_act  = (fh < H_ACT_W) && ({1'b0, fv} < V_ACT_W);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fx_reg     <= '0;
      fy_reg     <= '0;
      fvalid_reg <= 1'b0;
    end else if (tick) begin
      fx_reg     <= f_act ? fh[CW-1:0] : '0;
      fy_reg     <= f_act ? fv : '0;
      fvalid_reg <= f_act;
    end
  end

  assign fetch_x     = fx_reg;
  assign fetch_y     = fy_reg;
  assign fetch_valid = fvalid_reg;
`endif

endmodule
